// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and helpers for the set-associative instruction cache
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } cache_state_e;

    // Widest line the word selector accepts (ByteOffsetBits up to 7).
    localparam int MaxLineBits = 1024;

    function automatic logic [31:0] word_sel(input logic [MaxLineBits-1:0] line,
                                             input logic [4:0]             offset);
        return line[{offset, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: valid bits, tag and data arrays
module icache_way #(
    parameter int IndexBits = 6,
    parameter int TagBits   = 22,
    parameter int LineSize  = 128
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [IndexBits-1:0] rd_index_i,
    output logic                 rd_valid_o,
    output logic [TagBits-1:0]   rd_tag_o,
    output logic [LineSize-1:0]  rd_data_o,
    input  logic                 wr_en_i,
    input  logic [IndexBits-1:0] wr_index_i,
    input  logic [TagBits-1:0]   wr_tag_i,
    input  logic [LineSize-1:0]  wr_data_i,
    input  logic                 flush_i
);
    localparam int NrSets = 2**IndexBits;

    logic [NrSets-1:0]   valid_q;
    logic [TagBits-1:0]  tag_q  [NrSets];
    logic [LineSize-1:0] data_q [NrSets];

    // Flush dominates a same-cycle install.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_set_assoc.sv
// rtl/icache_set_assoc.sv - read-only N-way instruction cache with line refill, flush and counters
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int  NrWays         = 2,
    parameter int  IndexBits      = 6,
    parameter int  ByteOffsetBits = 4,
    localparam int LineSize       = 32 * ((2**ByteOffsetBits) / 4)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [31:0]         addr_i,
    input  logic                read_en_i,
    output logic                read_valid_o,
    output logic [31:0]         read_word_o,
    input  logic                flush_i,
    output logic [31:0]         mem_addr_o,
    output logic                mem_read_en_o,
    input  logic                mem_read_valid_i,
    input  logic [LineSize-1:0] mem_read_data_i,
    output logic [31:0]         hit_count_o,
    output logic [31:0]         miss_count_o
);
    localparam int TagBits        = 32 - IndexBits - ByteOffsetBits;
    localparam int NrSets         = 2**IndexBits;
    localparam int NrWordsPerLine = (2**ByteOffsetBits) / 4;
    localparam int WayBits        = (NrWays > 1) ? $clog2(NrWays) : 1;

    cache_state_e         state_q, state_d;
    logic [TagBits-1:0]   tag_q, tag_d;
    logic [IndexBits-1:0] index_q, index_d;
    logic [WayBits-1:0]   victim_q, victim_d;
    logic                 flushed_q, flushed_d;
    logic [WayBits-1:0]   rr_q [NrSets];
    logic [31:0]          hit_cnt_q, miss_cnt_q;

    logic [TagBits-1:0]   req_tag;
    logic [IndexBits-1:0] req_index;
    logic [4:0]           word_idx;
    logic [NrWays-1:0]    way_valid, match;
    logic [TagBits-1:0]   way_tag  [NrWays];
    logic [LineSize-1:0]  way_data [NrWays];
    logic [WayBits-1:0]   hit_way, alloc_way;
    logic                 any_match, inv_found, hit, miss_start, install;
    logic [MaxLineBits-1:0] line_ext;

    assign req_tag   = addr_i[31 -: TagBits];
    assign req_index = addr_i[ByteOffsetBits +: IndexBits];
    assign word_idx  = 5'((addr_i >> 2) & 32'(NrWordsPerLine - 1));

    for (genvar w = 0; w < NrWays; w++) begin : g_way
        icache_way #(
            .IndexBits (IndexBits),
            .TagBits   (TagBits),
            .LineSize  (LineSize)
        ) u_way (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .rd_index_i (req_index),
            .rd_valid_o (way_valid[w]),
            .rd_tag_o   (way_tag[w]),
            .rd_data_o  (way_data[w]),
            .wr_en_i    (install && (victim_q == WayBits'(w))),
            .wr_index_i (index_q),
            .wr_tag_i   (tag_q),
            .wr_data_i  (mem_read_data_i),
            .flush_i    (flush_i)
        );
        assign match[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    // Descending scans so the lowest-numbered way wins.
    always_comb begin
        hit_way   = '0;
        alloc_way = rr_q[req_index];
        inv_found = 1'b0;
        for (int w = NrWays - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WayBits'(w);
            if (!way_valid[w]) begin
                alloc_way = WayBits'(w);
                inv_found = 1'b1;
            end
        end
    end

    assign any_match = |match;
    assign hit       = read_en_i && (state_q == IDLE) && any_match && !flush_i;

    always_comb begin
        line_ext                = '0;
        line_ext[LineSize-1:0]  = way_data[hit_way];
    end

    assign read_valid_o  = hit;
    assign read_word_o   = hit ? word_sel(line_ext, word_idx) : 32'h0;
    assign mem_read_en_o = (state_q == REFILL);
    assign mem_addr_o    = (state_q == REFILL) ? {tag_q, index_q, {ByteOffsetBits{1'b0}}} : 32'h0;
    assign hit_count_o   = hit_cnt_q;
    assign miss_count_o  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        index_d    = index_q;
        victim_d   = victim_q;
        flushed_d  = flushed_q;
        miss_start = 1'b0;
        install    = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_en_i && !any_match && !flush_i) begin
                    state_d    = REFILL;
                    tag_d      = req_tag;
                    index_d    = req_index;
                    victim_d   = alloc_way;
                    flushed_d  = 1'b0;
                    miss_start = 1'b1;
                end
            end
            REFILL: begin
                if (flush_i) flushed_d = 1'b1;
                if (mem_read_valid_i) begin
                    state_d = IDLE;
                    install = !flush_i && !flushed_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            victim_q   <= '0;
            flushed_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < NrSets; s++) rr_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            victim_q  <= victim_d;
            flushed_q <= flushed_d;
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_start && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (install) rr_q[index_q] <= (NrWays == 1) ? '0 : rr_q[index_q] + 1'b1;
        end
    end

    a_single_match: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(match));

endmodule

// File: tb/tb_icache_set_assoc.sv
// tb/tb_icache_set_assoc.sv - scoreboard bench for icache_set_assoc
module tb_icache_set_assoc;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [31:0]  addr_i;
    logic         read_en_i;
    logic         read_valid_o;
    logic [31:0]  read_word_o;
    logic         flush_i;
    logic [31:0]  mem_addr_o;
    logic         mem_read_en_o;
    logic         mem_read_valid_i;
    logic [127:0] mem_read_data_i;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    int n_cmp = 0;
    int n_fail = 0;
    int mem_lat = 3;
    int mem_cnt = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] exp_q[$];

    icache_set_assoc #(.NrWays(2), .IndexBits(6), .ByteOffsetBits(4)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .addr_i           (addr_i),
        .read_en_i        (read_en_i),
        .read_valid_o     (read_valid_o),
        .read_word_o      (read_word_o),
        .flush_i          (flush_i),
        .mem_addr_o       (mem_addr_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_read_valid_i (mem_read_valid_i),
        .mem_read_data_i  (mem_read_data_i),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] w;
        w = (a >> 2) * 32'h9E37_79B1;
        return w ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: answers a held request after mem_lat cycles with a one-cycle pulse.
    always @(posedge clk_i) begin
        #1;
        if (mem_read_valid_i) begin
            mem_read_valid_i = 1'b0;
        end else if (mem_read_en_o) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_cnt = 0;
                for (int k = 0; k < 4; k++)
                    mem_read_data_i[k*32 +: 32] = mword(mem_addr_o + 32'(4 * k));
                mem_read_valid_i = 1'b1;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic fetch(input logic [31:0] a, input bit exp_miss, input string nm);
        int cyc, en_cyc, bad_addr;
        bit got;
        logic [31:0] exp;
        exp_q.push_back(mword(a & ~32'h3));
        @(posedge clk_i); #1;
        addr_i = a; read_en_i = 1'b1;
        cyc = 0; en_cyc = 0; bad_addr = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk_i);
            cyc++;
            if (mem_read_en_o) begin
                en_cyc++;
                if (mem_addr_o !== (a & ~32'hF)) bad_addr++;
            end
            if (read_valid_o) got = 1'b1;
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: no read_valid_o after %0d cycles, required within 64", nm, cyc);
        end else if (read_word_o !== exp) begin
            n_fail++;
            $display("FAIL %s word: got %h required %h", nm, read_word_o, exp);
        end
        n_cmp++;
        if (cyc != (exp_miss ? mem_lat + 2 : 1)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required %0d", nm, cyc, exp_miss ? mem_lat + 2 : 1);
        end
        if (exp_miss) begin
            n_cmp++;
            if (en_cyc != mem_lat || bad_addr != 0) begin
                n_fail++;
                $display("FAIL %s refill: en cycles %0d bad addr %0d, required %0d and 0", nm, en_cyc, bad_addr, mem_lat);
            end
            exp_misses++;
        end
        exp_hits++;
        @(posedge clk_i); #1;
        read_en_i = 1'b0;
    endtask

    task automatic wait_mem_en(input logic level, input string nm);
        int n = 0;
        while (mem_read_en_o !== level && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        n_cmp++;
        if (mem_read_en_o !== level) begin
            n_fail++;
            $display("FAIL %s mem_read_en_o: got %b required %b", nm, mem_read_en_o, level);
        end
    endtask

    task automatic test_counters(input string nm);
        n_cmp++;
        if (hit_count_o !== 32'(exp_hits) || miss_count_o !== 32'(exp_misses)) begin
            n_fail++;
            $display("FAIL %s counters: got hit %0d miss %0d required hit %0d miss %0d",
                     nm, hit_count_o, miss_count_o, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; addr_i = 32'h104; read_en_i = 1'b1; flush_i = 1'b0;
        mem_read_valid_i = 1'b0; mem_read_data_i = '0;
        #12;
        n_cmp++;
        if ({read_valid_o, mem_read_en_o} !== 2'b00 || read_word_o !== 32'h0 || mem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset outputs: valid %b mem_en %b word %h maddr %h required all 0",
                     read_valid_o, mem_read_en_o, read_word_o, mem_addr_o);
        end
        test_counters("reset");
        read_en_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_0104, 1'b1, "cold_miss");
        test_counters("cold_miss");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        @(posedge clk_i); #1;
        for (int i = 0; i < 4; i++) begin
            addr_i = 32'h100 + 32'(4 * i); read_en_i = 1'b1;
            exp_q.push_back(mword(addr_i));
            @(negedge clk_i);
            exp = exp_q.pop_front();
            n_cmp++;
            if (read_valid_o !== 1'b1 || read_word_o !== exp) begin
                n_fail++;
                $display("FAIL seq[%0d]: valid %b word %h required 1 %h", i, read_valid_o, read_word_o, exp);
            end
            exp_hits++;
            @(posedge clk_i); #1;
        end
        read_en_i = 1'b0;
        test_counters("seq");
    endtask

    task automatic test_replacement();
        fetch(32'h0000, 1'b1, "fill_a");
        fetch(32'h0400, 1'b1, "fill_b");
        fetch(32'h0008, 1'b0, "hit_a");
        fetch(32'h040C, 1'b0, "hit_b");
        fetch(32'h0800, 1'b1, "evict_a");
        fetch(32'h0404, 1'b0, "keep_b");
        fetch(32'h0000, 1'b1, "refetch_a");
        test_counters("replacement");
    endtask

    task automatic test_flush_idle();
        @(posedge clk_i); #1;
        addr_i = 32'h104; read_en_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (read_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle hit: got %b required 0", read_valid_o);
        end
        @(posedge clk_i); #1;
        flush_i = 1'b0; read_en_i = 1'b0;
        @(negedge clk_i);
        test_counters("flush_idle");
    endtask

    task automatic test_addr_change();
        int bad = 0, seen = 0;
        @(posedge clk_i); #1;
        addr_i = 32'h100; read_en_i = 1'b1;
        exp_misses++;
        wait_mem_en(1'b1, "addr_change start");
        @(posedge clk_i); #1;
        addr_i = 32'h200; read_en_i = 1'b0;
        for (int n = 0; n < 20 && mem_read_en_o === 1'b1; n++) begin
            @(negedge clk_i);
            if (mem_read_en_o === 1'b1) begin
                seen++;
                if (mem_addr_o !== 32'h100) bad++;
            end
        end
        n_cmp++;
        if (bad != 0 || seen == 0 || mem_read_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_change mem_addr: bad %0d seen %0d en %b required 0 >0 0", bad, seen, mem_read_en_o);
        end
        fetch(32'h200, 1'b1, "addr_change other");
        fetch(32'h10C, 1'b0, "addr_change installed");
        test_counters("addr_change");
    endtask

    task automatic test_flush_refill();
        @(posedge clk_i); #1;
        addr_i = 32'h300; read_en_i = 1'b1;
        exp_misses++;
        wait_mem_en(1'b1, "flush_refill start");
        @(posedge clk_i); #1;
        flush_i = 1'b1; read_en_i = 1'b0;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        wait_mem_en(1'b0, "flush_refill done");
        fetch(32'h304, 1'b1, "flush_refill not_installed");
        fetch(32'h100, 1'b1, "flush_refill cleared");
        test_counters("flush_refill");
    endtask

    task automatic test_reset_mid_refill();
        @(posedge clk_i); #1;
        addr_i = 32'h500; read_en_i = 1'b1;
        wait_mem_en(1'b1, "reset_mid start");
        @(posedge clk_i); #2;
        rstn_i = 1'b0;
        #1;
        exp_hits = 0; exp_misses = 0;
        n_cmp++;
        if (mem_read_en_o !== 1'b0 || read_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid async: mem_en %b valid %b required 0 0", mem_read_en_o, read_valid_o);
        end
        test_counters("reset_mid");
        read_en_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        fetch(32'h100, 1'b1, "reset_mid refetch");
        test_counters("reset_mid after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_replacement();
        test_flush_idle();
        test_addr_change();
        test_flush_refill();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
